rv_fetch_buffer: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the bare PC register, the PC+4 adder and the combinational IMEM read with three pieces: a request/response instruction-memory port that tolerates multi-cycle latency, an in-order prefetch buffer of configurable depth, and a valid/ready hand-off into the IF/ID register. Branch and jump redirects from Execute flush the buffer and discard all in-flight responses.

---
 rtl/rv_pipeline_pkg.sv | 8 +
 rtl/rv_fetch_buffer_if.sv | 30 +++
 rtl/rv_fetch_buffer_chk.sv | 10 +
 rtl/rv_sync_fifo.sv | 62 ++++++
 rtl/rv_fetch_buffer.sv | 110 +++++++++++
 tb/tb_rv_fetch_buffer.sv | 310 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rv_pipeline_pkg.sv
// Shared constants for the pipelined RV32 core.
// Defaults used by the fetch front end and the IF/ID flush NOP.
package rv_pipeline_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;
endpackage

// File: rtl/rv_fetch_buffer_if.sv
// Instruction-memory, redirect and decode hand-off signals of the fetch front end.
// The master modport is the fetch buffer; the slave modport is its surroundings.
interface rv_fetch_buffer_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pc_plus_4;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus_4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus_4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               dec_ready
    );
endinterface

// File: rtl/rv_fetch_buffer_chk.sv
// Property checks for the fetch buffer; carries no functional logic.
module rv_fetch_buffer_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic pop,
    input logic full
);
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
endmodule

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush input; head data and count come straight from flops.
module rv_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        do_pop_s  = pop && (count_r != CW'(0));
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy; clear empties the FIFO without touching data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (clear) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (count_r == CW'(0));
    assign full    = (count_r == CW'(DEPTH));
    assign count   = count_r;
endmodule

// File: rtl/rv_fetch_buffer.sv
// Instruction-fetch front end: credit-limited IMEM requests, in-order prefetch FIFO,
// and redirect handling that squashes responses still in flight.
module rv_fetch_buffer
    import rv_pipeline_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input logic              clk,
    input logic              reset,
    rv_fetch_buffer_if.master bus
);
    localparam int              CW      = $clog2(DEPTH+1);
    localparam int              IW      = CW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] head_pc_r;
    logic [XLEN-1:0] head_pc_p4_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   count_s;
    logic [CW-1:0]   out_after_rsp_s;
    logic [IW-1:0]   inflight_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic [31:0]     fifo_data_s;

    // Credit check uses registered occupancy only, so a same-cycle pop earns nothing.
    always_comb begin
        inflight_s  = {1'b0, count_s} + {1'b0, outstanding_r};
        req_valid_s = !reset && !bus.redirect_valid && (inflight_s < IW'(DEPTH));
        req_fire_s  = req_valid_s && bus.imem_req_ready;
        rsp_s       = bus.imem_rsp_valid;
        pop_s       = !fifo_empty_s && bus.dec_ready;
        push_s      = rsp_s && (drop_cnt_r == CW'(0)) && !bus.redirect_valid;
        if (rsp_s && (outstanding_r != CW'(0))) begin
            out_after_rsp_s = outstanding_r - CW'(1);
        end else begin
            out_after_rsp_s = outstanding_r;
        end
    end

    // PC and credit bookkeeping; a redirect overrides every other event in its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            head_pc_r     <= RESET_PC;
            head_pc_p4_r  <= RESET_PC + PC_STEP;
            outstanding_r <= CW'(0);
            drop_cnt_r    <= CW'(0);
        end else if (bus.redirect_valid) begin
            fetch_pc_r    <= bus.redirect_pc;
            head_pc_r     <= bus.redirect_pc;
            head_pc_p4_r  <= bus.redirect_pc + PC_STEP;
            outstanding_r <= out_after_rsp_s;
            // Every response still owed belongs to the old path.
            drop_cnt_r    <= out_after_rsp_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (pop_s) begin
                head_pc_r    <= head_pc_p4_r;
                head_pc_p4_r <= head_pc_p4_r + PC_STEP;
            end
            outstanding_r <= out_after_rsp_s + CW'(req_fire_s);
            if (rsp_s && (drop_cnt_r != CW'(0))) begin
                drop_cnt_r <= drop_cnt_r - CW'(1);
            end
        end
    end

    rv_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.redirect_valid),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (bus.imem_rsp_data),
        .rd_data (fifo_data_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .count   (count_s)
    );

    rv_fetch_buffer_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .full  (fifo_full_s)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.dec_valid      = !fifo_empty_s;
    assign bus.dec_instr      = fifo_data_s;
    assign bus.dec_pc         = head_pc_r;
    assign bus.dec_pc_plus_4  = head_pc_p4_r;
endmodule

// File: tb/tb_rv_fetch_buffer.sv
// Self-checking bench for rv_fetch_buffer: queue-based in-order memory with variable
// latency, plus a reference model of the fetch and decode PC streams.
module tb_rv_fetch_buffer;
    localparam int          XLEN    = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] XOR_KEY = 32'h0000_00A5;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv_fetch_buffer_if #(.XLEN(XLEN)) bus ();

    rv_fetch_buffer #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mreq_t       mem_q[$];
    int          cyc;
    int          checks;
    int          errors;
    logic        rst_want;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic        obs_req_valid, obs_fire, obs_pop, obs_dec_valid, obs_rsp;
    logic [31:0] obs_addr, obs_pc, obs_instr, obs_p4;

    // One clock cycle: drive at negedge, let memory answer, sample just after.
    task automatic step(input logic rdy, input logic drdy, input logic redir,
                        input logic [31:0] tgt, input int lat);
        @(negedge clk);
        reset              = rst_want;
        bus.imem_req_ready = rdy;
        bus.dec_ready      = drdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        obs_rsp            = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_q[0].addr ^ XOR_KEY;
            obs_rsp            = 1'b1;
            void'(mem_q.pop_front());
        end
        #1;
        obs_req_valid = bus.imem_req_valid;
        obs_addr      = bus.imem_req_addr;
        obs_dec_valid = bus.dec_valid;
        obs_pc        = bus.dec_pc;
        obs_instr     = bus.dec_instr;
        obs_p4        = bus.dec_pc_plus_4;
        obs_fire      = obs_req_valid && rdy;
        obs_pop       = obs_dec_valid && drdy;
        if (obs_fire) mem_q.push_back('{addr: obs_addr, due: cyc + lat});
        cyc++;
    endtask

    // Reference PC model: sequential stream, restarted at the target on redirect.
    task automatic advance_model(input logic redir, input logic [31:0] tgt);
        if (obs_fire) exp_fetch = exp_fetch + 32'd4;
        if (obs_pop)  exp_pc    = exp_pc + 32'd4;
        if (redir) begin
            exp_fetch = tgt;
            exp_pc    = tgt;
        end
    endtask

    task automatic do_reset();
        rst_want = 1'b1;
        mem_q.delete();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        rst_want  = 1'b0;
        exp_fetch = RST_PC;
        exp_pc    = RST_PC;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", obs_req_valid); end
        checks++; if (obs_addr !== RST_PC) begin errors++; $display("FAIL reset_req_addr got %h want %h", obs_addr, RST_PC); end
        checks++; if (obs_dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b want 0", obs_dec_valid); end
        checks++; if (obs_instr !== 32'h0) begin errors++; $display("FAIL reset_dec_instr got %h want 0", obs_instr); end
        checks++; if (obs_pc !== RST_PC) begin errors++; $display("FAIL reset_dec_pc got %h want %h", obs_pc, RST_PC); end
        checks++; if (obs_p4 !== RST_PC + 32'd4) begin errors++; $display("FAIL reset_dec_pc4 got %h want %h", obs_p4, RST_PC + 32'd4); end
    endtask

    task automatic test_startup();
        int first_req = -1;
        int first_dv  = -1;
        int n_fire    = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (obs_fire) begin
                n_fire++;
                if (first_req < 0) first_req = i;
                checks++; if (obs_addr !== exp_fetch) begin errors++; $display("FAIL startup_req_addr got %h want %h", obs_addr, exp_fetch); end
            end
            if (obs_dec_valid && first_dv < 0) first_dv = i;
            if (obs_pop) begin
                checks++;
                if (obs_pc !== exp_pc || obs_instr !== (exp_pc ^ XOR_KEY) || obs_p4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL startup_dec got %h/%h/%h want %h/%h/%h", obs_pc, obs_instr, obs_p4, exp_pc, exp_pc ^ XOR_KEY, exp_pc + 32'd4);
                end
            end
            advance_model(1'b0, 32'h0);
        end
        checks++; if (first_req !== 0) begin errors++; $display("FAIL startup_first_req cycle got %0d want 0", first_req); end
        checks++; if (first_dv !== 2) begin errors++; $display("FAIL startup_first_dec_valid cycle got %0d want 2", first_dv); end
        checks++; if (n_fire !== 6) begin errors++; $display("FAIL startup_back_to_back requests got %0d want 6", n_fire); end
    endtask

    task automatic test_stall();
        int n_fire = 0;
        int n_pop  = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1);
            if (obs_fire) begin
                n_fire++;
                checks++; if (obs_addr !== exp_fetch) begin errors++; $display("FAIL stall_req_addr got %h want %h", obs_addr, exp_fetch); end
            end
            advance_model(1'b0, 32'h0);
        end
        checks++; if (n_fire !== DEPTH) begin errors++; $display("FAIL stall_request_count got %0d want %0d", n_fire, DEPTH); end
        checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid_held got %b want 0", obs_req_valid); end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (obs_fire) begin
                checks++; if (obs_addr !== exp_fetch) begin errors++; $display("FAIL stall_release_req_addr got %h want %h", obs_addr, exp_fetch); end
            end
            if (obs_pop) begin
                n_pop++;
                checks++;
                if (obs_pc !== exp_pc || obs_instr !== (exp_pc ^ XOR_KEY) || obs_p4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL stall_release_dec got %h/%h/%h want %h/%h/%h", obs_pc, obs_instr, obs_p4, exp_pc, exp_pc ^ XOR_KEY, exp_pc + 32'd4);
                end
            end
            advance_model(1'b0, 32'h0);
        end
        checks++; if (n_pop < DEPTH) begin errors++; $display("FAIL stall_release_pops got %0d want at least %0d", n_pop, DEPTH); end
    endtask

    task automatic test_redirect_stale();
        int n_fire = 0;
        int n_pop  = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 3);
            if (obs_fire) n_fire++;
            advance_model(1'b0, 32'h0);
        end
        checks++; if (n_fire !== 3) begin errors++; $display("FAIL stale_outstanding got %0d want 3", n_fire); end
        step(1'b1, 1'b1, 1'b1, 32'h0000_0400, 3);
        checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL stale_req_in_redirect got %b want 0", obs_req_valid); end
        advance_model(1'b1, 32'h0000_0400);
        step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        checks++; if (obs_dec_valid !== 1'b0) begin errors++; $display("FAIL stale_dec_valid_after got %b want 0", obs_dec_valid); end
        checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 32'h0000_0400) begin errors++; $display("FAIL stale_first_req got %b/%h want 1/00000400", obs_req_valid, obs_addr); end
        advance_model(1'b0, 32'h0);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 3);
            if (obs_fire) begin
                checks++; if (obs_addr !== exp_fetch) begin errors++; $display("FAIL stale_req_addr got %h want %h", obs_addr, exp_fetch); end
            end
            if (obs_pop) begin
                n_pop++;
                checks++;
                if (obs_pc !== exp_pc || obs_instr !== (exp_pc ^ XOR_KEY) || obs_p4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL stale_dec got %h/%h/%h want %h/%h/%h", obs_pc, obs_instr, obs_p4, exp_pc, exp_pc ^ XOR_KEY, exp_pc + 32'd4);
                end
            end
            advance_model(1'b0, 32'h0);
        end
        checks++; if (n_pop < 4) begin errors++; $display("FAIL stale_delivered got %0d want at least 4", n_pop); end
    endtask

    task automatic test_double_redirect();
        int n_pop = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 2);
            advance_model(1'b0, 32'h0);
        end
        step(1'b1, 1'b1, 1'b1, 32'h0000_0600, 2);
        checks++; if (!(obs_rsp && obs_pop)) begin errors++; $display("FAIL double_setup rsp/pop got %b/%b want 1/1", obs_rsp, obs_pop); end
        if (obs_pop) begin
            checks++; if (obs_pc !== exp_pc) begin errors++; $display("FAIL double_pop_in_redirect got %h want %h", obs_pc, exp_pc); end
        end
        advance_model(1'b1, 32'h0000_0600);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0800, 2);
        checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL double_req_in_redirect got %b want 0", obs_req_valid); end
        advance_model(1'b1, 32'h0000_0800);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 2);
            if (obs_fire) begin
                checks++; if (obs_addr !== exp_fetch) begin errors++; $display("FAIL double_req_addr got %h want %h", obs_addr, exp_fetch); end
            end
            if (obs_pop) begin
                n_pop++;
                checks++;
                if (obs_pc !== exp_pc || obs_instr !== (exp_pc ^ XOR_KEY) || obs_p4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL double_dec got %h/%h/%h want %h/%h/%h", obs_pc, obs_instr, obs_p4, exp_pc, exp_pc ^ XOR_KEY, exp_pc + 32'd4);
                end
            end
            advance_model(1'b0, 32'h0);
        end
        checks++; if (n_pop < 4) begin errors++; $display("FAIL double_delivered got %0d want at least 4", n_pop); end
        checks++; if (dut.drop_cnt_r !== 3'd0) begin errors++; $display("FAIL double_drop_cnt got %0d want 0", dut.drop_cnt_r); end
    endtask

    task automatic test_wrap();
        logic seen_req = 1'b0;
        logic seen_pop = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        do_reset();
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
        advance_model(1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (obs_fire) begin
                if (prev_addr == 32'hFFFF_FFFC && obs_addr == 32'h0) seen_req = 1'b1;
                prev_addr = obs_addr;
                checks++; if (obs_addr !== exp_fetch) begin errors++; $display("FAIL wrap_req_addr got %h want %h", obs_addr, exp_fetch); end
            end
            if (obs_pop) begin
                if (obs_pc == 32'hFFFF_FFFC && obs_p4 == 32'h0) seen_pop = 1'b1;
                checks++;
                if (obs_pc !== exp_pc || obs_instr !== (exp_pc ^ XOR_KEY) || obs_p4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL wrap_dec got %h/%h/%h want %h/%h/%h", obs_pc, obs_instr, obs_p4, exp_pc, exp_pc ^ XOR_KEY, exp_pc + 32'd4);
                end
            end
            advance_model(1'b0, 32'h0);
        end
        checks++; if (seen_req !== 1'b1) begin errors++; $display("FAIL wrap_fetch_to_zero got %b want 1", seen_req); end
        checks++; if (seen_pop !== 1'b1) begin errors++; $display("FAIL wrap_pc_plus_4_zero got %b want 1", seen_pop); end
    endtask

    task automatic test_random();
        int          n_pop = 0;
        int          n_cyc = 0;
        logic        rdy, dr, redir;
        logic [31:0] tgt;
        int          lat;
        do_reset();
        while (n_pop < 1000 && n_cyc < 20000) begin
            rdy   = 1'($urandom_range(0, 1));
            dr    = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 49) == 0);
            tgt   = $urandom() & 32'hFFFF_FFFC;
            lat   = int'($urandom_range(1, 5));
            step(rdy, dr, redir, tgt, lat);
            n_cyc++;
            if (redir) begin
                checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL random_req_in_redirect got %b want 0", obs_req_valid); end
            end
            if (obs_fire) begin
                checks++; if (obs_addr !== exp_fetch) begin errors++; $display("FAIL random_req_addr got %h want %h", obs_addr, exp_fetch); end
            end
            if (obs_pop) begin
                n_pop++;
                checks++;
                if (obs_pc !== exp_pc || obs_instr !== (exp_pc ^ XOR_KEY) || obs_p4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL random_dec got %h/%h/%h want %h/%h/%h", obs_pc, obs_instr, obs_p4, exp_pc, exp_pc ^ XOR_KEY, exp_pc + 32'd4);
                end
            end
            advance_model(redir, tgt);
        end
        checks++; if (n_pop < 1000) begin errors++; $display("FAIL random_budget delivered %0d want 1000", n_pop); end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        cyc                = 0;
        rst_want           = 1'b1;
        reset              = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.dec_ready      = 1'b0;
        exp_fetch          = RST_PC;
        exp_pc             = RST_PC;
        test_reset();
        test_startup();
        test_stall();
        test_redirect_stale();
        test_double_redirect();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
